// File: rtl/bp_common_pkg.sv
// bp_common_pkg: Sv39 constants, PTE layout and page-table-walker state encoding shared by bp_ptw.
package bp_common_pkg;
  localparam int sv39_levels_gp = 3;
  localparam int page_offset_width_gp = 12;
  localparam int sv39_vpn_width_gp = 9;
  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } bp_sv39_pte_s;
  typedef enum logic [2:0] {
    e_idle, e_send, e_wait, e_fill, e_fault, e_drain
  } bp_ptw_state_e;
  function automatic int bp_pte_leaf_width(input int paddr_width);
    return paddr_width - page_offset_width_gp + 7;
  endfunction
endpackage

// File: rtl/bp_ptw_pte_check.sv
// bp_ptw_pte_check: decodes one Sv39 PTE into fault / descend decisions and the splintered TLB fill entry.
module bp_ptw_pte_check
  import bp_common_pkg::*;
#(
  parameter int ptag_width_p = 28
) (
  input  logic [63:0]             pte_i,
  input  logic [1:0]              level_i,
  input  logic                    store_i,
  input  logic [17:0]             vpn10_i,
  output logic                    fault_o,
  output logic                    descend_o,
  output logic [ptag_width_p+6:0] entry_o
);
  bp_sv39_pte_s pte;
  logic invalid, leaf, misaligned, high, unused;
  logic [ptag_width_p-1:0] ptag;
  assign pte = pte_i;
  assign unused = ^{pte.reserved, pte.rsw, pte.g};
  assign invalid = ~pte.v | (~pte.r & pte.w);
  assign leaf = pte.r | pte.x;
  assign misaligned = (level_i == 2'd2 & |pte.ppn[17:0]) | (level_i == 2'd1 & |pte.ppn[8:0]);
  assign high = |(pte.ppn >> ptag_width_p);
  // A/D are never updated in hardware, so a missing A or store-without-D must trap
  assign fault_o = invalid | (leaf ? misaligned | ~pte.a | (store_i & ~pte.d) | high : level_i == 2'd0);
  assign descend_o = ~invalid & ~leaf & level_i != 2'd0;
  assign ptag = level_i == 2'd0 ? pte.ppn[ptag_width_p-1:0]
              : level_i == 2'd1 ? {pte.ppn[ptag_width_p-1:9], vpn10_i[8:0]}
              : {pte.ppn[ptag_width_p-1:18], vpn10_i};
  assign entry_o = {ptag, level_i == 2'd2, pte.a, pte.d, pte.u, pte.x, pte.w, pte.r};
endmodule

// File: rtl/bp_ptw.sv
// bp_ptw: Sv39 hardware page-table walker turning a TLB miss into a TLB fill or a page fault.
module bp_ptw
  import bp_common_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int paddr_width_p = 40,
  parameter int pte_width_p = 64,
  localparam int vtag_width_lp = vaddr_width_p - page_offset_width_gp,
  localparam int ptag_width_lp = paddr_width_p - page_offset_width_gp,
  localparam int entry_width_lp = bp_pte_leaf_width(paddr_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [43:0]               satp_ppn_i,
  input  logic                      miss_v_i,
  output logic                      miss_ready_o,
  input  logic                      miss_instr_i,
  input  logic                      miss_load_i,
  input  logic                      miss_store_i,
  input  logic [vtag_width_lp-1:0]  miss_vtag_i,
  output logic                      mem_v_o,
  output logic [paddr_width_p-1:0]  mem_addr_o,
  input  logic                      mem_ready_and_i,
  input  logic                      mem_v_i,
  input  logic [pte_width_p-1:0]    mem_data_i,
  output logic                      w_v_o,
  output logic [vtag_width_lp-1:0]  w_vtag_o,
  output logic [entry_width_lp-1:0] w_entry_o,
  output logic                      instr_page_fault_o,
  output logic                      load_page_fault_o,
  output logic                      store_page_fault_o,
  output logic                      busy_o
);
  bp_ptw_state_e state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [43:0] ppn_q, ppn_d;
  logic [vtag_width_lp-1:0] vtag_q, vtag_d, w_vtag_q, w_vtag_d;
  logic [2:0] type_q, type_d;
  logic [entry_width_lp-1:0] w_entry_q, w_entry_d, entry;
  logic [8:0] vpn;
  logic fault, descend, accept, resp;
  bp_ptw_pte_check #(.ptag_width_p(ptag_width_lp)) check (
    .pte_i(mem_data_i[63:0]), .level_i(level_q), .store_i(type_q[0]), .vpn10_i(vtag_q[17:0]),
    .fault_o(fault), .descend_o(descend), .entry_o(entry)
  );
  assign vpn = level_q == 2'd2 ? vtag_q[26:18] : level_q == 2'd1 ? vtag_q[17:9] : vtag_q[8:0];
  assign accept = state_q == e_idle & ~flush_i & miss_v_i;
  assign resp = state_q == e_wait & ~flush_i & mem_v_i;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_q <= e_idle;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle:  state_d = accept ? e_send : e_idle;
      e_send:  state_d = mem_ready_and_i ? (flush_i ? e_drain : e_wait) : (flush_i ? e_idle : e_send);
      e_wait:  state_d = flush_i ? (mem_v_i ? e_idle : e_drain)
                       : ~mem_v_i ? e_wait : fault ? e_fault : descend ? e_send : e_fill;
      e_drain: state_d = mem_v_i ? e_idle : e_drain;
      default: state_d = e_idle;
    endcase
  end
  always_comb begin
    miss_ready_o = state_q == e_idle & ~flush_i;
    mem_v_o = state_q == e_send;
    mem_addr_o = mem_v_o ? paddr_width_p'({ppn_q, 12'b0}) + paddr_width_p'({vpn, 3'b0}) : '0;
    w_v_o = state_q == e_fill & ~flush_i;
    {instr_page_fault_o, load_page_fault_o, store_page_fault_o} = state_q == e_fault & ~flush_i ? type_q : 3'b0;
    busy_o = state_q != e_idle;
  end
  always_comb begin
    ppn_d = accept ? satp_ppn_i : resp & descend ? mem_data_i[53:10] : ppn_q;
    level_d = accept ? 2'd2 : resp & descend ? level_q - 2'd1 : level_q;
    vtag_d = accept ? miss_vtag_i : vtag_q;
    type_d = accept ? {miss_instr_i, miss_load_i, miss_store_i} : type_q;
    w_vtag_d = resp ? vtag_q : w_vtag_q;
    w_entry_d = resp ? entry : w_entry_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      level_q <= '0;
      ppn_q <= '0;
      vtag_q <= '0;
      type_q <= '0;
      w_vtag_q <= '0;
      w_entry_q <= '0;
    end else begin
      level_q <= level_d;
      ppn_q <= ppn_d;
      vtag_q <= vtag_d;
      type_q <= type_d;
      w_vtag_q <= w_vtag_d;
      w_entry_q <= w_entry_d;
    end
  assign w_vtag_o = w_vtag_q;
  assign w_entry_o = w_entry_q;
endmodule

// File: doc/bp_ptw.md
# bp_ptw

Hardware Sv39 page-table walker: accepts a TLB miss from the MMU, walks the in-memory page table one PTE per memory transaction, and returns either a TLB fill (vtag + PTE leaf) into the MMU's write port or a page fault. One walk is in flight at a time. Sits between `bp_mmu` (miss producer / fill consumer) and the cache or memory request path.

## Interface
- `vaddr_width_p`, 39: virtual address width; vtag = 27 bits (3 × 9-bit VPN).
- `paddr_width_p`, 40: physical address width; ptag = `paddr_width_p`-12 = 28 bits.
- `pte_width_p`, 64: PTE size; one PTE per memory response.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: abort the current walk (sfence/satp change).
- `satp_ppn_i` in 44: root page-table PPN, sampled when a miss is accepted.
- `miss_v_i` in 1: miss request valid.
- `miss_ready_o` out 1: high only in IDLE.
- `miss_instr_i`, `miss_load_i`, `miss_store_i` in 1 each: access type, one-hot.
- `miss_vtag_i` in 27: faulting VPN.
- `mem_v_o` out 1: PTE read request valid.
- `mem_addr_o` out `paddr_width_p`: PTE physical address.
- `mem_ready_and_i` in 1: request accepted when `mem_v_o & mem_ready_and_i`.
- `mem_v_i` in 1: response valid; always accepted.
- `mem_data_i` in 64: PTE.
- `w_v_o` out 1: TLB fill pulse.
- `w_vtag_o` out 27: fill vtag.
- `w_entry_o` out `bp_pte_leaf_width(paddr_width_p)`: {ptag, gigapage, a, d, u, x, w, r}.
- `instr_page_fault_o`, `load_page_fault_o`, `store_page_fault_o` out 1 each: fault pulse.
- `busy_o` out 1: not IDLE.

## Operation
- States: IDLE, SEND, WAIT, FILL, FAULT, DRAIN.
- IDLE: when `miss_v_i`, latch vtag, type, and `satp_ppn_i` as the current PPN; set level = 2; go to SEND.
- SEND: `mem_addr_o` = (ppn << 12) + vpn[level] × 8, truncated to `paddr_width_p`. Hold until `mem_ready_and_i`, then go to WAIT.
- WAIT: on `mem_v_i`, decode the PTE: V=0, R=1, W=2, X=3, U=4, A=6, D=7, PPN=[53:10].
  - Invalid, i.e. ~V or (~R & W) → FAULT.
  - Non-leaf, i.e. ~R & ~X:
    - level 0 → FAULT.
    - otherwise: ppn = PTE.PPN, level−1, go to SEND.
  - Leaf checks, each → FAULT:
    - level 2 with PPN[17:0] ≠ 0, or level 1 with PPN[8:0] ≠ 0 (misaligned superpage).
    - ~A, or store & ~D (no hardware A/D update).
    - PPN bits above ptag width nonzero.
  - Leaf that passes all checks → FILL.
- Fill entry contents:
  - level 0: ptag = PPN, gigapage = 0.
  - level 1 (2M): splinter to 4K; ptag = {PPN[27:9], vpn0}, gigapage = 0.
  - level 2: ptag = {PPN[27:18], vpn1, vpn0}, gigapage = 1.
  - All levels: flags copied from the PTE.
- FILL: `w_v_o` = 1 for one cycle, then IDLE.
- FAULT: assert the fault output matching the latched type for one cycle, then IDLE.
- `flush_i`:
  - IDLE/FILL/FAULT: the FILL or FAULT pulse is suppressed and the next state is IDLE.
  - SEND: if the request handshakes that same cycle → DRAIN; otherwise → IDLE.
  - WAIT: → DRAIN, unless `mem_v_i` is also high that cycle, in which case the response is dropped and the next state is IDLE.
- DRAIN: discard the next `mem_v_i`, then IDLE. No fill or fault is produced.

## Timing
- Reset values: state IDLE; all outputs 0, except `miss_ready_o` = 1.
- Reset mid-walk returns to IDLE immediately; a later in-flight response arriving in IDLE is ignored.
- Miss accepted at cycle 0; SEND occupies cycle 1 at the earliest.
- Each level costs ≥ 2 cycles plus memory latency.
- `w_v_o` or fault asserts 1 cycle after the final `mem_v_i`.
- A new miss can be accepted the cycle after FILL/FAULT.
- `w_vtag_o` and `w_entry_o` are registered and stable while `w_v_o` is high.
- `mem_addr_o` is stable while `mem_v_o` is high.

## Structure
- Shared package (`bp_common_pkg`):
  - `bp_sv39_pte_s` struct.
  - Sv39 constants: levels = 3, page offset = 12, vpn width = 9.
  - PTW state enum.
- One sub-module, `bp_ptw_pte_check`: combinational leaf/invalid/misaligned/permission decode, which keeps the FSM file small.

## Test plan
- 4K walk, satp_ppn = 0x80000, vtag = {1, 2, 3}:
  - requests at 0x8000_0008, 0x8000_1010, 0x8000_2018, given PTEs with ppn 0x80001 and 0x80002.
  - leaf ppn 0x80010 with VRWAD → `w_v_o`, ptag 0x80010, gigapage 0.
- Gigapage: level-2 leaf with ppn 0x40000, VRXA → gigapage = 1, ptag = {0x001, vpn1, vpn0}, after exactly one request.
- Misaligned gigapage: ppn 0x40001 on a load → `load_page_fault_o` pulse, no `w_v_o`.
- Store to a leaf with A = 1, D = 0 → `store_page_fault_o`; the same PTE on a load fills normally.
- Flush in WAIT, response 3 cycles later → no fill or fault; `miss_ready_o` rises the cycle after the response.
- `mem_ready_and_i` low for 4 cycles in SEND → `mem_v_o` and `mem_addr_o` held constant; async reset mid-WAIT → all outputs 0 immediately.
